// File: rtl/machine_timer_if.sv
// Data-bus port of the machine timer: core-side request strobes and the
// registered response returned by the timer.
interface machine_timer_if;
    logic        cs;
    logic [4:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    modport master (
        output cs, addr, wr_en, rd_en, wdata,
        input  rdata, rvalid, err
    );

    modport slave (
        input  cs, addr, wr_en, rd_en, wdata,
        output rdata, rvalid, err
    );
endinterface

// File: rtl/machine_timer_unit.sv
// Memory-mapped machine timer: prescaled 64-bit mtime, 64-bit mtimecmp and a
// level timer_irq toward the core's mip.MTIP.
module machine_timer_unit #(
    parameter int PRESC_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    machine_timer_if.slave bus,
    output logic           timer_irq
);
    localparam logic [4:0] OFF_MTIME_LO = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI = 5'h04;
    localparam logic [4:0] OFF_CMP_LO   = 5'h08;
    localparam logic [4:0] OFF_CMP_HI   = 5'h0C;
    localparam logic [4:0] OFF_CTRL     = 5'h10;

    logic [63:0]        mtime;
    logic [63:0]        mtimecmp;
    logic               cnt_en;
    logic               irq_en;
    logic [PRESC_W-1:0] div;
    logic [PRESC_W-1:0] presc_cnt;

    logic        rd_req;
    logic        wr_req;
    logic        off_ok;
    logic        tick;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_ctrl;
    logic [31:0] ctrl_word;
    logic [31:0] rd_word;

    always_comb begin
        rd_req      = bus.cs & bus.rd_en;
        wr_req      = bus.cs & bus.wr_en;
        off_ok      = (bus.addr[1:0] == 2'b00) && (bus.addr <= OFF_CTRL);
        // Exact offset matches already exclude the misaligned and out-of-window cases
        wr_mtime_lo = wr_req && (bus.addr == OFF_MTIME_LO);
        wr_mtime_hi = wr_req && (bus.addr == OFF_MTIME_HI);
        wr_cmp_lo   = wr_req && (bus.addr == OFF_CMP_LO);
        wr_cmp_hi   = wr_req && (bus.addr == OFF_CMP_HI);
        wr_ctrl     = wr_req && (bus.addr == OFF_CTRL);
        tick        = cnt_en && (presc_cnt == div);
    end

    always_comb begin
        ctrl_word              = '0;
        ctrl_word[0]           = cnt_en;
        ctrl_word[1]           = irq_en;
        ctrl_word[8 +: PRESC_W] = div;
        case (bus.addr)
            OFF_MTIME_LO: rd_word = mtime[31:0];
            OFF_MTIME_HI: rd_word = mtime[63:32];
            OFF_CMP_LO:   rd_word = mtimecmp[31:0];
            OFF_CMP_HI:   rd_word = mtimecmp[63:32];
            OFF_CTRL:     rd_word = ctrl_word;
            default:      rd_word = '0;
        endcase
    end

    // A CTRL write restarts the divide period from zero
    always_ff @(posedge clk) begin
        if (reset || wr_ctrl || !cnt_en || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // Bus writes to either mtime half take priority over a same-cycle tick
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime <= '0;
        end else if (wr_mtime_lo) begin
            mtime <= {mtime[63:32], bus.wdata};
        end else if (wr_mtime_hi) begin
            mtime <= {bus.wdata, mtime[31:0]};
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mtimecmp <= '1;
        end else if (wr_cmp_lo) begin
            mtimecmp <= {mtimecmp[63:32], bus.wdata};
        end else if (wr_cmp_hi) begin
            mtimecmp <= {bus.wdata, mtimecmp[31:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_en <= 1'b0;
            irq_en <= 1'b0;
            div    <= '0;
        end else if (wr_ctrl) begin
            cnt_en <= bus.wdata[0];
            irq_en <= bus.wdata[1];
            div    <= bus.wdata[8 +: PRESC_W];
        end
    end

    // rd_word reflects pre-edge state, so a same-cycle write or tick is not visible
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            bus.rvalid <= rd_req;
            bus.err    <= (rd_req || wr_req) && !off_ok;
            if (rd_req) begin
                bus.rdata <= off_ok ? rd_word : 32'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_irq <= 1'b0;
        end else begin
            timer_irq <= irq_en && (mtime >= mtimecmp);
        end
    end
endmodule

// File: tb/tb_machine_timer_unit.sv
// Scoreboard bench for machine_timer_unit: directed bus sequences push the
// expected response, a negedge monitor pops and compares each response.
module tb_machine_timer_unit;
    logic clk;
    logic reset;
    logic timer_irq;

    machine_timer_if bus ();

    machine_timer_unit #(.PRESC_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .timer_irq (timer_irq)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        rvalid;
        logic        err;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Monitor: every response the DUT presents must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus.rvalid === 1'b1 || bus.err === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_response actual rvalid=%0b err=%0b rdata=%0h required none",
                         bus.rvalid, bus.err, bus.rdata);
            end else begin
                e = q.pop_front();
                if (bus.rvalid !== e.rvalid || bus.err !== e.err ||
                    (e.rvalid && bus.rdata !== e.rdata)) begin
                    errors++;
                    $display("FAIL %s actual rvalid=%0b err=%0b rdata=%0h required rvalid=%0b err=%0b rdata=%0h",
                             e.name, bus.rvalid, bus.err, bus.rdata, e.rvalid, e.err, e.rdata);
                end
            end
        end
    end

    task automatic bus_idle();
        bus.cs    = 1'b0;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.addr  = 5'h0;
        bus.wdata = 32'h0;
    endtask

    task automatic op(input logic c, input logic r, input logic w, input logic [4:0] a,
                      input logic [31:0] d, input logic [31:0] exp_d, input logic exp_rv,
                      input logic exp_er, input string nm);
        exp_t e;
        bus.cs    = c;
        bus.rd_en = r;
        bus.wr_en = w;
        bus.addr  = a;
        bus.wdata = d;
        if (exp_rv || exp_er) begin
            e.rdata  = exp_d;
            e.rvalid = exp_rv;
            e.err    = exp_er;
            e.name   = nm;
            q.push_back(e);
        end
        @(negedge clk);
        bus_idle();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        op(1'b1, 1'b0, 1'b1, a, d, 32'h0, 1'b0, 1'b0, "write");
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp_d, input string nm);
        op(1'b1, 1'b1, 1'b0, a, 32'h0, exp_d, 1'b1, 1'b0, nm);
    endtask

    task automatic idle(input int n);
        bus_idle();
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus_idle();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("reset_rdata", bus.rdata, 0);
        chk("reset_rvalid", bus.rvalid, 0);
        chk("reset_err", bus.err, 0);
        chk("reset_irq", timer_irq, 0);
        rd(5'h00, 32'h0, "rst_mtime_lo");
        rd(5'h04, 32'h0, "rst_mtime_hi");
        rd(5'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(5'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(5'h10, 32'h0, "rst_ctrl");
        idle(2);

        // div = 3: ticks every 4 cycles, 10 ticks after 40 cycles
        wr(5'h10, 32'h0000_0301);
        idle(40);
        rd(5'h00, 32'd10, "div3_after40");
        rd(5'h00, 32'd10, "div3_b2b_1");
        rd(5'h00, 32'd10, "div3_b2b_2");
        rd(5'h00, 32'd10, "div3_b2b_3");
        rd(5'h00, 32'd11, "div3_next_tick");
        wr(5'h10, 32'h0000_0001);
        rd(5'h00, 32'd11, "div0_step0");
        rd(5'h00, 32'd12, "div0_step1");
        rd(5'h00, 32'd13, "div0_step2");

        // 64-bit wrap, and write-over-tick priority
        wr(5'h00, 32'hFFFF_FFFF);
        wr(5'h04, 32'hFFFF_FFFF);
        rd(5'h04, 32'hFFFF_FFFF, "wrap_pre_hi");
        rd(5'h00, 32'h0, "wrap_lo");
        rd(5'h04, 32'h0, "wrap_hi");
        wr(5'h00, 32'd5);
        rd(5'h00, 32'd5, "write_beats_tick");

        // Interrupt at mtime == mtimecmp == 20
        wr(5'h10, 32'h0);
        wr(5'h00, 32'h0);
        wr(5'h08, 32'd20);
        wr(5'h0C, 32'h0);
        wr(5'h10, 32'h0000_0003);
        for (int i = 1; i <= 22; i++) begin
            idle(1);
            chk($sformatf("irq_cycle%0d", i), timer_irq, (i >= 21) ? 1 : 0);
        end
        wr(5'h0C, 32'h1);
        chk("irq_hold_on_cmp_write", timer_irq, 1);
        idle(1);
        chk("irq_drop_after_cmp_write", timer_irq, 0);

        // Freeze mtime at 25, then invalid and deselected accesses
        wr(5'h10, 32'h0000_0002);
        op(1'b1, 1'b1, 1'b0, 5'h14, 32'h0, 32'h0, 1'b1, 1'b1, "invalid_read");
        op(1'b1, 1'b0, 1'b1, 5'h02, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1, "misaligned_write");
        rd(5'h00, 32'd25, "no_change_after_invalid");
        rd(5'h10, 32'h0000_0002, "ctrl_readback");
        op(1'b0, 1'b0, 1'b1, 5'h00, 32'h77, 32'h0, 1'b0, 1'b0, "cs0_write");
        op(1'b0, 1'b1, 1'b0, 5'h00, 32'h0, 32'h0, 1'b0, 1'b0, "cs0_read");
        chk("rdata_hold", bus.rdata, 32'h0000_0002);
        chk("cs0_no_rvalid", bus.rvalid, 0);
        rd(5'h00, 32'd25, "no_change_after_cs0");
        op(1'b1, 1'b1, 1'b1, 5'h08, 32'h55, 32'd20, 1'b1, 1'b0, "rdwr_returns_old");
        rd(5'h08, 32'h55, "rdwr_write_done");

        // Reset mid-count with the interrupt asserted
        wr(5'h08, 32'd20);
        wr(5'h0C, 32'h0);
        wr(5'h10, 32'h0000_0003);
        idle(2);
        chk("irq_before_reset", timer_irq, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("post_reset_irq", timer_irq, 0);
        chk("post_reset_rdata", bus.rdata, 0);
        chk("post_reset_rvalid", bus.rvalid, 0);
        idle(3);
        rd(5'h00, 32'h0, "post_reset_mtime_lo");
        rd(5'h04, 32'h0, "post_reset_mtime_hi");
        rd(5'h08, 32'hFFFF_FFFF, "post_reset_cmp_lo");
        rd(5'h0C, 32'hFFFF_FFFF, "post_reset_cmp_hi");
        rd(5'h10, 32'h0, "post_reset_ctrl");
        idle(2);
        chk("post_reset_irq_low", timer_irq, 0);
        chk("scoreboard_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
